// File: rtl/reg_file_mp.sv
// Multi-port register file with hardwired constant registers, a dedicated load-return register
// and a sequential bulk-clear engine. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_mp #(
    parameter int DW        = 8,
    parameter int PW        = 3,
    parameter int NUM_CONST = 2,
    parameter int DED_IDX   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          MemtoReg,
    input  logic [DW-1:0] mem_dat_in,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    input  logic          clr_req,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic [DW-1:0] dedReg_out,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam int            DEPTH     = 2**PW;
    localparam logic [PW-1:0] DED_ADDR  = PW'(DED_IDX);
    localparam logic [PW:0]   CONST_LIM = (PW+1)'(NUM_CONST);
    localparam logic [PW:0]   LAST_IDX  = (PW+1)'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [PW:0]   r_clrIdx;
    logic [DW-1:0] r_mem [NUM_CONST:DEPTH-1];
    logic [DW-1:0] w_view [DEPTH];
    logic          w_clearing;
    logic          w_memWr;
    logic          w_portWr;

    // Writeback loses to the load return on the dedicated register, and nothing lands on constants.
    assign w_clearing = (r_state == CLEAR);
    assign w_memWr    = MemtoReg && !w_clearing;
    assign w_portWr   = wr_en && !w_clearing && ({1'b0, wr_addr} >= CONST_LIM)
                        && !(MemtoReg && (wr_addr == DED_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (clr_req) w_nextState = CLEAR;
            CLEAR:   if (r_clrIdx == LAST_IDX) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        clr_busy = (r_state == CLEAR);
        clr_done = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_clrIdx <= CONST_LIM;
        else if (r_state == CLEAR) r_clrIdx <= r_clrIdx + (PW+1)'(1);
        else                       r_clrIdx <= CONST_LIM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = NUM_CONST; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = NUM_CONST; i < DEPTH; i++) begin
                if (w_clearing && (r_clrIdx == (PW+1)'(i)))  r_mem[i] <= '0;
                else if (w_memWr && (i == DED_IDX))          r_mem[i] <= mem_dat_in;
                else if (w_portWr && (wr_addr == PW'(i)))    r_mem[i] <= dat_in;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_view
        if (g < NUM_CONST) begin : g_const
            assign w_view[g] = DW'(g);
        end else begin : g_store
            assign w_view[g] = r_mem[g];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Forward committing writes straight to the read ports; load return takes priority.
    always_comb begin
        datA_out = w_view[rd_addrA];
        if (w_memWr && (rd_addrA == DED_ADDR))     datA_out = mem_dat_in;
        else if (w_portWr && (rd_addrA == wr_addr)) datA_out = dat_in;

        datB_out = w_view[rd_addrB];
        if (w_memWr && (rd_addrB == DED_ADDR))     datB_out = mem_dat_in;
        else if (w_portWr && (rd_addrB == wr_addr)) datB_out = dat_in;

        dedReg_out = w_view[DED_IDX];
        if (w_memWr)                                dedReg_out = mem_dat_in;
        else if (w_portWr && (wr_addr == DED_ADDR)) dedReg_out = dat_in;
    end
`else
    assign datA_out   = w_view[rd_addrA];
    assign datB_out   = w_view[rd_addrB];
    assign dedReg_out = w_view[DED_IDX];
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] dat_in;
    logic       MemtoReg;
    logic [7:0] mem_dat_in;
    logic [2:0] rd_addrA;
    logic [2:0] rd_addrB;
    logic       clr_req;
    logic [7:0] datA_out;
    logic [7:0] datB_out;
    logic [7:0] dedReg_out;
    logic       clr_busy;
    logic       clr_done;

    int errors = 0;
    int checks = 0;

    // Reference model: register contents plus clear phase (0 idle, 1 clearing, 2 done).
    logic [7:0] model [8];
    int         phase;
    int         clrNext;

    reg_file_mp #(.DW(8), .PW(3), .NUM_CONST(2), .DED_IDX(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .dat_in     (dat_in),
        .MemtoReg   (MemtoReg),
        .mem_dat_in (mem_dat_in),
        .rd_addrA   (rd_addrA),
        .rd_addrB   (rd_addrB),
        .clr_req    (clr_req),
        .datA_out   (datA_out),
        .datB_out   (datB_out),
        .dedReg_out (dedReg_out),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectRead(input int addr);
        if (addr < 2) return 8'(addr);
`ifdef REG_FILE_BYPASS_EN
        if (phase != 1) begin
            if (MemtoReg && addr == 2) return mem_dat_in;
            if (wr_en && int'(wr_addr) == addr) return dat_in;
        end
`endif
        return model[addr];
    endfunction

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        phase   = 0;
        clrNext = 2;
    endfunction

    // Drive one cycle from a falling edge, check outputs before the rising edge, then advance the model.
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                 input logic m2r, input logic [7:0] md,
                                 input logic [2:0] ra, input logic [2:0] rb, input logic cr);
        wr_en = we; wr_addr = wa; dat_in = wd;
        MemtoReg = m2r; mem_dat_in = md;
        rd_addrA = ra; rd_addrB = rb; clr_req = cr;
        #1;
        checkOutput("datA", 32'(datA_out), 32'(expectRead(int'(ra))));
        checkOutput("datB", 32'(datB_out), 32'(expectRead(int'(rb))));
        checkOutput("dedReg", 32'(dedReg_out), 32'(expectRead(2)));
        checkOutput("clr_busy", 32'(clr_busy), 32'(phase == 1));
        checkOutput("clr_done", 32'(clr_done), 32'(phase == 2));
        @(posedge clk);
        if (phase == 1) begin
            model[clrNext] = 8'h00;
            clrNext++;
            if (clrNext == 8) phase = 2;
        end else begin
            if (m2r) model[2] = md;
            if (we && int'(wa) >= 2 && !(m2r && wa == 3'd2)) model[wa] = wd;
            if (phase == 2) phase = 0;
            else if (cr) begin
                phase   = 1;
                clrNext = 2;
            end
        end
        @(negedge clk);
    endtask

    task automatic idleStep(input logic [2:0] ra, input logic [2:0] rb);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, ra, rb, 1'b0);
    endtask

    initial begin
        int busyCount;
        modelReset();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; dat_in = '0; MemtoReg = 1'b0;
        mem_dat_in = '0; rd_addrA = '0; rd_addrB = '0; clr_req = 1'b0;

        for (int a = 0; a < 8; a++) begin
            rd_addrA = 3'(a);
            rd_addrB = 3'(7 - a);
            #1;
            checkOutput("reset_readA", 32'(datA_out), (a < 2) ? 32'(a) : 32'h0);
            checkOutput("reset_readB", 32'(datB_out), 32'(expectRead(7 - a)));
        end
        checkOutput("reset_busy", 32'(clr_busy), 32'h0);
        checkOutput("reset_done", 32'(clr_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 3'd1, 8'hAA, 1'b0, 8'h00, 3'd1, 3'd0, 1'b0);
        idleStep(3'd1, 3'd0);
        checkOutput("const1_after_write", 32'(datA_out), 32'h01);

        applyStimulus(1'b1, 3'd5, 8'h3C, 1'b0, 8'h00, 3'd5, 3'd5, 1'b0);
        idleStep(3'd5, 3'd5);
        checkOutput("reg5_next_cycle", 32'(datA_out), 32'h3C);

        applyStimulus(1'b1, 3'd2, 8'h22, 1'b1, 8'h11, 3'd2, 3'd0, 1'b0);
        idleStep(3'd2, 3'd0);
        checkOutput("memtoreg_priority", 32'(dedReg_out), 32'h11);

        applyStimulus(1'b1, 3'd6, 8'h66, 1'b1, 8'h44, 3'd2, 3'd6, 1'b0);
        idleStep(3'd2, 3'd6);
        checkOutput("dual_write_reg2", 32'(datA_out), 32'h44);
        checkOutput("dual_write_reg6", 32'(datB_out), 32'h66);

        for (int a = 2; a < 8; a++) applyStimulus(1'b1, 3'(a), 8'hFF, 1'b0, 8'h00, 3'(a), 3'd4, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd4, 3'd7, 1'b1);
        busyCount = 0;
        for (int k = 0; k < 20; k++) begin
            if (!clr_busy) break;
            busyCount++;
            applyStimulus(1'b1, 3'd4, 8'h99, 1'b0, 8'h00, 3'd4, 3'd7, 1'b0);
        end
        checkOutput("busy_cycles", 32'(busyCount), 32'd6);
        checkOutput("done_pulse", 32'(clr_done), 32'h1);
        for (int a = 0; a < 8; a++) idleStep(3'(a), 3'(7 - a));
        checkOutput("reg4_dropped", 32'(model[4]), 32'h0);

        applyStimulus(1'b1, 3'd7, 8'h77, 1'b1, 8'h22, 3'd7, 3'd5, 1'b0);
        applyStimulus(1'b1, 3'd5, 8'h55, 1'b0, 8'h00, 3'd7, 3'd5, 1'b0);
        applyStimulus(1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 3'd7, 3'd5, 1'b1);
        idleStep(3'd7, 3'd5);
        idleStep(3'd7, 3'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_datA", 32'(datA_out), 32'h0);
        checkOutput("abort_datB", 32'(datB_out), 32'h0);
        checkOutput("abort_ded", 32'(dedReg_out), 32'h0);
        checkOutput("abort_busy", 32'(clr_busy), 32'h0);
        checkOutput("abort_done", 32'(clr_done), 32'h0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("abort_done_edge", 32'(clr_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) idleStep(3'd7, 3'(k));
        applyStimulus(1'b1, 3'd7, 8'h5A, 1'b0, 8'h00, 3'd7, 3'd2, 1'b0);
        idleStep(3'd7, 3'd2);
        checkOutput("post_abort_write", 32'(datA_out), 32'h5A);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                          1'($urandom_range(0, 3) == 0), 8'($urandom),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the 8x8 core register file: configurable data width and depth, and configurable hardwired constant registers.
- Two write ports: an ALU/writeback port, and a load-return port dedicated to one register.
- Adds asynchronous reset and a sequential bulk-clear engine with a busy/done handshake.
- Sits between decode (read addresses), writeback, and data memory (load return) in the single-cycle core.

Parameters:
- DW, 8, data width in bits.
- PW, 3, address pointer width; depth = 2**PW.
- NUM_CONST, 2, number of low registers that are read-only constants; register i (i < NUM_CONST) reads as value i.
- DED_IDX, 2, index of the dedicated load register exposed on dedReg_out; must be >= NUM_CONST and < 2**PW.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  writeback port enable.
- wr_addr  in  PW  writeback address.
- dat_in  in  DW  writeback data.
- MemtoReg  in  1  load-return enable; writes mem_dat_in to register DED_IDX.
- mem_dat_in  in  DW  load-return data.
- rd_addrA  in  PW  read pointer A.
- rd_addrB  in  PW  read pointer B.
- clr_req  in  1  request a bulk clear of all writable registers; sampled only in IDLE.
- datA_out  out  DW  combinational read of rd_addrA.
- datB_out  out  DW  combinational read of rd_addrB.
- dedReg_out  out  DW  combinational view of register DED_IDX.
- clr_busy  out  1  high while the clear engine runs.
- clr_done  out  1  one-cycle pulse when a clear completes.

Behaviour:
- Reset (rst_n low, asynchronous): all writable registers = 0; FSM = IDLE; clear index = NUM_CONST; clr_busy = 0; clr_done = 0. Outputs reflect zeroed storage immediately.
- Constant registers:
  - Registers 0..NUM_CONST-1 are not storage. They always read as their own index, zero-extended to DW.
  - Writes to them on either port are silently dropped.
- Reads:
  - Combinational, zero latency.
  - Without the optional feature, a read in the same cycle as a write to the same address returns the old value; the new value is visible the cycle after the edge.
- Writes: sequential, one-cycle latency.
  - MemtoReg=1 writes mem_dat_in to DED_IDX.
  - wr_en=1 writes dat_in to wr_addr.
  - Both in the same cycle with wr_addr != DED_IDX: both writes commit.
  - Both in the same cycle with wr_addr == DED_IDX: MemtoReg wins; dat_in is dropped.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 moves to CLEAR next edge; index = NUM_CONST; clr_busy rises that edge.
  - CLEAR: each cycle, register[index] <= 0 and index increments. When index == 2**PW-1 is cleared, go to DONE. Busy lasts exactly 2**PW - NUM_CONST cycles (6 at defaults).
  - DONE: clr_done=1 and clr_busy=0 for one cycle; then IDLE.
  - While in CLEAR, both write ports are ignored (writes dropped, not queued). Reads continue and show partially cleared contents.
  - clr_req while in CLEAR or DONE is ignored. Holding clr_req high through DONE starts a new clear on the following IDLE cycle.
  - Reset asserted mid-clear aborts the clear: all registers are zero, FSM is IDLE, and no clr_done pulse occurs.
- Index counter is PW+1 bits wide so the compare does not wrap at 2**PW-1.
- Writes that arrive in DONE are accepted normally.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding on datA_out, datB_out and dedReg_out.
  - If a read address matches an enabled, committing write in the same cycle, the output shows the incoming data combinationally.
  - The same MemtoReg-over-wr_en priority applies.
  - Never forwards to constant registers, or while clr_busy=1.
- Undefined: no forwarding; reads show the registered value only.

Test Plan:
- Reset then read all 8 addresses -> reg0=0x00, reg1=0x01, others 0x00; write wr_addr=1, dat_in=0xAA -> reg1 still reads 0x01.
- wr_en, wr_addr=5, dat_in=0x3C -> datA_out(rd_addrA=5) = 0x3C the cycle after the edge. Without bypass, the same-cycle read = 0x00; with REG_FILE_BYPASS_EN, the same-cycle read = 0x3C.
- Same cycle: MemtoReg=1, mem_dat_in=0x11 and wr_en=1, wr_addr=2, dat_in=0x22 -> dedReg_out = 0x11.
- Same cycle: MemtoReg=1, mem_dat_in=0x44 and wr_en, wr_addr=6, dat_in=0x66 -> reg2=0x44 and reg6=0x66.
- Fill regs 2..7 with 0xFF, pulse clr_req -> clr_busy high for exactly 6 cycles, clr_done pulses 1 cycle, all regs 0x00. A wr_en write to reg4 during busy is dropped.
- Start a clear, assert rst_n=0 on the 3rd busy cycle -> outputs zero immediately, clr_busy=0, no clr_done; after release, a normal write to reg7=0x5A succeeds.
